multi_counter_display: RTL and testbench
========================================

MULTI_COUNTER_DISPLAY -- requirements
Module: multi_counter_display

Interface
REQ-001 SHALL have parameter MODE, default "HEX": count display radix, "HEX" or "DEC".
REQ-002 SHALL have parameter NUM_CHANNELS, default 2: number of independent button counters, 1..4.
REQ-003 SHALL have parameter DIGITS_PER_CHANNEL, default 4: display digits per channel, 1..4.
REQ-004 SHALL have parameter CLK_PER, default 10: clock period in ns.
REQ-005 SHALL have parameter REFR_RATE, default 1000: full-display refresh rate in Hz.
REQ-006 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: stable cycles required to accept a button level, at least 1.
REQ-007 SHALL have parameter BLANK_LZ, default 0: 1 blanks leading zero digits per channel.
REQ-008 SHALL have port clk, input, 1 bit: the single clock.
REQ-009 SHALL have port CPU_RESET, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port BTN, input, NUM_CHANNELS bits: asynchronous raw buttons, one per channel.
REQ-011 SHALL have port CLR, input, NUM_CHANNELS bits: synchronous per-channel count clear, active-high.
REQ-012 SHALL have port anode, output, TOTAL_DIGITS = NUM_CHANNELS*DIGITS_PER_CHANNEL bits: active-low one-hot digit enable.
REQ-013 SHALL have port cathode, output, 8 bits: active-low segments, bit 7 = decimal point.

Function
REQ-014 SHALL pass each BTN bit through a 2-flop synchroniser, then a debouncer; the debounced level SHALL change only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 SHALL increment channel c exactly 1 cycle after its debounced level rises 0->1; releases and bounces SHALL NOT count.
REQ-016 SHALL, in HEX mode, count in binary across 4*DIGITS_PER_CHANNEL bits and wrap from all-F to 0.
REQ-017 SHALL, in DEC mode, hold one BCD digit per display digit with ripple carry and wrap from all-9 to 0; no digit SHALL ever hold a value above 9.
REQ-018 SHALL give CLR[c] priority over a simultaneous increment on the same channel: count becomes 0 and the increment is dropped.
REQ-019 SHALL update channels independently; simultaneous events on different channels SHALL all take effect in the same cycle.
REQ-020 SHALL scan digits with localparam DIGIT_TICKS = 1e9/(CLK_PER*REFR_RATE*TOTAL_DIGITS), minimum 1; each digit SHALL be held DIGIT_TICKS cycles, in order 0..TOTAL_DIGITS-1, then wrap to 0.
REQ-021 SHALL map digit index d to channel d/DIGITS_PER_CHANNEL, nibble d%DIGITS_PER_CHANNEL, with nibble 0 least significant; anode bit d low while digit d is active.
REQ-022 SHALL register anode and cathode together so they change on the same edge, with no cycle in which the anode and cathode refer to different digits.
REQ-023 SHALL, with BLANK_LZ=1, drive cathode 8'hFF for a zero nibble above the channel's most significant non-zero nibble; nibble 0 SHALL never be blanked.
REQ-024 SHALL keep the decimal point off (cathode[7]=1) at all times.

Reset
REQ-025 SHALL, while CPU_RESET is high at a clk edge, clear all counts, synchroniser flops, debounce counters and debounced levels to 0, and reset the scan index and tick counter to 0.
REQ-026 SHALL drive anode all-ones and cathode 8'hFF on the cycle after reset is sampled; scanning SHALL resume at digit 0 after reset is released.
REQ-027 SHALL discard a press in progress when reset is asserted mid-debounce; a held button SHALL count again only after release and a new press.

Structure
REQ-028 SHALL put the 7-segment encode table (nibble to active-low cathode, 0-F) and the MODE string constants in package seg7_pkg.
REQ-029 SHALL instantiate one sub-module, button_debounce (synchroniser plus debouncer), per channel; counting, BCD logic and scan SHALL stay in the top level.

Verification
REQ-030 SHALL check a clean press: NUM_CHANNELS=2, DEBOUNCE_CYCLES=4, BTN[0] held high 20 cycles -> channel 0 = 1, channel 1 = 0.
REQ-031 SHALL check bounce rejection: BTN[0] toggled every 2 cycles for 20 cycles, then held low -> count unchanged.
REQ-032 SHALL check DEC wrap: MODE="DEC", DIGITS_PER_CHANNEL=2, count 99 plus one press -> 00; count 09 plus one press -> 10 with no A-F nibble.
REQ-033 SHALL check HEX wrap: DIGITS_PER_CHANNEL=1, 16 presses -> 0; CLR[1] and a BTN[1] edge in the same cycle -> channel 1 = 0.
REQ-034 SHALL check the scan: CLK_PER=10, REFR_RATE=3_125_000, TOTAL_DIGITS=4 -> DIGIT_TICKS=8; anode sequence 1110, 1101, 1011, 0111, each held 8 cycles; channel 0 = 5 shows cathode 8'h92 on digit 0.
REQ-035 SHALL check reset mid-operation: CPU_RESET pulsed 1 cycle during a debounce with counts non-zero -> counts 0, anode all-ones for 1 cycle, scan restarts at digit 0, and the held button does not count.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Seven-segment encode table and display radix constants shared by
//            the multi-channel counter display.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Values accepted by the MODE parameter of the top level
    localparam logic [23:0] c_MODE_HEX = "HEX";
    localparam logic [23:0] c_MODE_DEC = "DEC";

    // All segments and the decimal point dark (active-low)
    localparam logic [7:0] c_SEG_BLANK = 8'hFF;

    // Nibble to active-low cathode pattern, bit 7 is the decimal point (kept off)
    function automatic logic [7:0] seg7_encode(input logic [3:0] i_nib);
        logic [7:0] w_seg;
        case (i_nib)
            4'h0:    w_seg = 8'hC0;
            4'h1:    w_seg = 8'hF9;
            4'h2:    w_seg = 8'hA4;
            4'h3:    w_seg = 8'hB0;
            4'h4:    w_seg = 8'h99;
            4'h5:    w_seg = 8'h92;
            4'h6:    w_seg = 8'h82;
            4'h7:    w_seg = 8'hF8;
            4'h8:    w_seg = 8'h80;
            4'h9:    w_seg = 8'h90;
            4'hA:    w_seg = 8'h88;
            4'hB:    w_seg = 8'h83;
            4'hC:    w_seg = 8'hC6;
            4'hD:    w_seg = 8'hA1;
            4'hE:    w_seg = 8'h86;
            default: w_seg = 8'h8E;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Brief    : Two-flop synchroniser followed by a level debouncer. After reset
//            the debouncer stays disarmed until the button is seen released,
//            so a button held through reset cannot produce a press.
// Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [1:0]         r_vld;
    logic               r_armed;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;

    // Synchronise, track pipeline validity, arm on a real release, debounce
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            // r_sync[1] only reflects the pin once both flops reloaded after reset
            r_vld  <= {r_vld[0], 1'b1};
            if (r_vld[1] && !r_sync[1]) begin
                r_armed <= 1'b1;
            end
            if (!r_armed || (r_sync[1] == r_level)) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/multi_counter_display.sv
`default_nettype none
// ============================================================================
// Module   : multi_counter_display
// Brief    : Per-channel debounced button counters (HEX or BCD) shown on a
//            multiplexed, active-low seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module multi_counter_display
    import seg7_pkg::*;
#(
    parameter     MODE               = "HEX",
    parameter int NUM_CHANNELS       = 2,
    parameter int DIGITS_PER_CHANNEL = 4,
    parameter int CLK_PER            = 10,
    parameter int REFR_RATE          = 1000,
    parameter int DEBOUNCE_CYCLES    = 1_000_000,
    parameter int BLANK_LZ           = 0
) (
    input  logic                                       clk,
    input  logic                                       CPU_RESET,
    input  logic [NUM_CHANNELS-1:0]                    BTN,
    input  logic [NUM_CHANNELS-1:0]                    CLR,
    output logic [NUM_CHANNELS*DIGITS_PER_CHANNEL-1:0] anode,
    output logic [7:0]                                 cathode
);

    localparam int c_TOTAL     = NUM_CHANNELS * DIGITS_PER_CHANNEL;
    localparam int c_CNT_W     = 4 * DIGITS_PER_CHANNEL;
    localparam bit c_IS_DEC    = (MODE == c_MODE_DEC);
    localparam int c_TICKS_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE * c_TOTAL);
    localparam int DIGIT_TICKS = (c_TICKS_RAW < 1) ? 1 : c_TICKS_RAW;
    localparam int c_TICK_W    = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int c_IDX_W     = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(DIGIT_TICKS - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(c_TOTAL - 1);

    logic                                 rst;
    logic [NUM_CHANNELS-1:0]              w_level;
    logic [NUM_CHANNELS-1:0]              r_level_d;
    logic [NUM_CHANNELS-1:0][c_CNT_W-1:0] r_count;
    logic [c_TICK_W-1:0]                  r_tick;
    logic [c_IDX_W-1:0]                   r_idx;
    logic [c_TOTAL-1:0]                   w_anode;
    logic [c_TOTAL-1:0]                   r_anode;
    logic [7:0]                           r_cathode;
    logic [3:0]                           w_nib   [c_TOTAL];
    logic                                 w_blank [c_TOTAL];

    assign rst = CPU_RESET;

    // BCD increment with ripple carry; digits at 9 (or corrupt) roll to 0
    function automatic logic [c_CNT_W-1:0] bcd_inc(input logic [c_CNT_W-1:0] i_val);
        logic [c_CNT_W-1:0] w_res;
        logic               w_carry;
        w_res   = i_val;
        w_carry = 1'b1;
        for (int k = 0; k < DIGITS_PER_CHANNEL; k++) begin
            if (w_carry) begin
                if (i_val[4*k +: 4] >= 4'd9) begin
                    w_res[4*k +: 4] = 4'd0;
                end else begin
                    w_res[4*k +: 4] = i_val[4*k +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
        end
        return w_res;
    endfunction

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (BTN[c]),
            .o_level(w_level[c])
        );
    end

    // Count debounced rising edges per channel; clear wins over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_level_d <= '0;
        end else begin
            r_level_d <= w_level;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (CLR[c]) begin
                    r_count[c] <= '0;
                end else if (w_level[c] && !r_level_d[c]) begin
                    r_count[c] <= c_IS_DEC ? bcd_inc(r_count[c]) : r_count[c] + 1'b1;
                end
            end
        end
    end

    // Flatten channel counts into per-digit nibbles, anode bits and blanking
    for (genvar d = 0; d < c_TOTAL; d++) begin : g_digit
        localparam int c_CH  = d / DIGITS_PER_CHANNEL;
        localparam int c_NIB = d % DIGITS_PER_CHANNEL;
        assign w_nib[d]   = r_count[c_CH][4*c_NIB +: 4];
        assign w_anode[d] = (r_idx != c_IDX_W'(d));
        if (c_NIB == 0) begin : g_lsd
            assign w_blank[d] = 1'b0;
        end else begin : g_upper
            // Blank only when this nibble and everything above it are zero
            assign w_blank[d] = (BLANK_LZ != 0) && (r_count[c_CH][c_CNT_W-1:4*c_NIB] == '0);
        end
    end

    // Step the scan and register anode and cathode from the same digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick    <= '0;
            r_idx     <= '0;
            r_anode   <= '1;
            r_cathode <= c_SEG_BLANK;
        end else begin
            r_anode   <= w_anode;
            r_cathode <= w_blank[r_idx] ? c_SEG_BLANK : seg7_encode(w_nib[r_idx]);
            if (r_tick == c_TICK_LAST) begin
                r_tick <= '0;
                r_idx  <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_tick <= r_tick + 1'b1;
            end
        end
    end

    assign anode   = r_anode;
    assign cathode = r_cathode;

endmodule
`default_nettype wire

// File: tb/tb_multi_counter_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_counter_display
// Brief    : Self-checking bench with three display configurations: HEX with
//            two digits per channel, HEX with one digit per channel, and DEC
//            with leading-zero blanking. All use 8-cycle digit dwell.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_counter_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a, clr_a, btn_b, clr_b, btn_c, clr_c;
    logic [3:0] anode_a, anode_c;
    logic [1:0] anode_b;
    logic [7:0] cath_a, cath_b, cath_c;

    int checks   = 0;
    int failures = 0;

    // Free-running clock
    always #5 clk = ~clk;

    multi_counter_display #(
        .MODE("HEX"), .NUM_CHANNELS(2), .DIGITS_PER_CHANNEL(2), .CLK_PER(10),
        .REFR_RATE(3_125_000), .DEBOUNCE_CYCLES(4), .BLANK_LZ(0)
    ) u_dut_a (
        .clk(clk), .CPU_RESET(rst), .BTN(btn_a), .CLR(clr_a), .anode(anode_a), .cathode(cath_a)
    );

    multi_counter_display #(
        .MODE("HEX"), .NUM_CHANNELS(2), .DIGITS_PER_CHANNEL(1), .CLK_PER(10),
        .REFR_RATE(6_250_000), .DEBOUNCE_CYCLES(4), .BLANK_LZ(0)
    ) u_dut_b (
        .clk(clk), .CPU_RESET(rst), .BTN(btn_b), .CLR(clr_b), .anode(anode_b), .cathode(cath_b)
    );

    multi_counter_display #(
        .MODE("DEC"), .NUM_CHANNELS(2), .DIGITS_PER_CHANNEL(2), .CLK_PER(10),
        .REFR_RATE(3_125_000), .DEBOUNCE_CYCLES(4), .BLANK_LZ(1)
    ) u_dut_c (
        .clk(clk), .CPU_RESET(rst), .BTN(btn_c), .CLR(clr_c), .anode(anode_c), .cathode(cath_c)
    );

    // Reference seven-segment patterns, active-low, decimal point off
    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    typedef struct {
        int         inst;
        int         digit;
        logic [7:0] exp;
    } exp_t;

    typedef struct {
        int         inst;
        logic [1:0] mask;
        int         npress;
        bit         clr;
        int         exp0;
        int         exp1;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[12];

    function automatic logic [3:0] get_anode(input int inst);
        case (inst)
            0:       return anode_a;
            1:       return {2'b11, anode_b};
            default: return anode_c;
        endcase
    endfunction

    function automatic logic [7:0] get_cath(input int inst);
        case (inst)
            0:       return cath_a;
            1:       return cath_b;
            default: return cath_c;
        endcase
    endfunction

    function automatic int digits_of(input int inst);
        return (inst == 1) ? 1 : 2;
    endfunction

    // Expected cathode for one nibble of a channel showing 'count'
    function automatic logic [7:0] exp_cath(input int inst, input int count, input int nib);
        int b;
        int p;
        int v;
        b = (inst == 2) ? 10 : 16;
        p = 1;
        for (int k = 0; k < nib; k++) p = p * b;
        v = (count / p) % b;
        if (inst == 2 && nib > 0 && count < p) return 8'hFF;
        return seg_tab[v];
    endfunction

    task automatic set_btn(input int inst, input logic [1:0] v);
        case (inst)
            0:       btn_a = v;
            1:       btn_b = v;
            default: btn_c = v;
        endcase
    endtask

    task automatic set_clr(input int inst, input logic [1:0] v);
        case (inst)
            0:       clr_a = v;
            1:       clr_b = v;
            default: clr_c = v;
        endcase
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Clean press: high 10 cycles then low 10 cycles
    task automatic press(input int inst, input logic [1:0] mask);
        set_btn(inst, mask);
        repeat (10) @(posedge clk);
        #1;
        set_btn(inst, 2'b00);
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic push_counts(input int inst, input int c0, input int c1);
        exp_t e;
        for (int ch = 0; ch < 2; ch++) begin
            for (int nib = 0; nib < digits_of(inst); nib++) begin
                e.inst  = inst;
                e.digit = ch * digits_of(inst) + nib;
                e.exp   = exp_cath(inst, (ch == 0) ? c0 : c1, nib);
                sb_q.push_back(e);
            end
        end
    endtask

    // Pop each expectation, wait for its digit to be scanned, compare cathode
    task automatic drain();
        exp_t       e;
        bit         found;
        logic [3:0] want;
        while (sb_q.size() > 0) begin
            e     = sb_q.pop_front();
            found = 1'b0;
            want  = 4'b0001 << e.digit;
            want  = ~want;
            for (int t = 0; t < 200 && !found; t++) begin
                @(negedge clk);
                if (get_anode(e.inst) === want) found = 1'b1;
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL scan_timeout inst=%0d digit=%0d got_anode=%b exp_anode=%b",
                         e.inst, e.digit, get_anode(e.inst), want);
            end else if (get_cath(e.inst) !== e.exp) begin
                failures++;
                $display("FAIL cathode inst=%0d digit=%0d got=%h exp=%h",
                         e.inst, e.digit, get_cath(e.inst), e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Hang guard
    initial begin
        #500_000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        logic [3:0] want;

        // inst, mask, presses, clear-first, expected ch0, expected ch1
        vecs[0]  = '{0, 2'b01,  1, 1'b0,  1,  0};
        vecs[1]  = '{0, 2'b01,  4, 1'b0,  5,  0};
        vecs[2]  = '{0, 2'b11,  2, 1'b0,  7,  2};
        vecs[3]  = '{0, 2'b10,  0, 1'b1,  7,  0};
        vecs[4]  = '{1, 2'b01, 15, 1'b0, 15,  0};
        vecs[5]  = '{1, 2'b01,  1, 1'b0,  0,  0};
        vecs[6]  = '{1, 2'b10,  2, 1'b0,  0,  2};
        vecs[7]  = '{2, 2'b01,  9, 1'b0,  9,  0};
        vecs[8]  = '{2, 2'b01,  1, 1'b0, 10,  0};
        vecs[9]  = '{2, 2'b01, 89, 1'b0, 99,  0};
        vecs[10] = '{2, 2'b11,  1, 1'b0,  0,  1};
        vecs[11] = '{2, 2'b10, 11, 1'b0,  0, 12};

        rst   = 1'b1;
        btn_a = '0; clr_a = '0;
        btn_b = '0; clr_b = '0;
        btn_c = '0; clr_c = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_anode_a", {4'h0, anode_a}, 8'h0F);
        chk("reset_anode_b", {6'h0, anode_b}, 8'h03);
        chk("reset_cath_a", cath_a, 8'hFF);
        chk("reset_cath_c", cath_c, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].clr) begin
                set_clr(vecs[i].inst, vecs[i].mask);
                @(posedge clk);
                #1;
                set_clr(vecs[i].inst, 2'b00);
            end
            for (int p = 0; p < vecs[i].npress; p++) press(vecs[i].inst, vecs[i].mask);
            push_counts(vecs[i].inst, vecs[i].exp0, vecs[i].exp1);
            drain();
        end

        // Bounce: toggle every 2 cycles, never stable for 4 cycles
        for (int i = 0; i < 10; i++) begin
            set_btn(0, (i % 2 == 0) ? 2'b01 : 2'b00);
            repeat (2) @(posedge clk);
            #1;
        end
        set_btn(0, 2'b00);
        repeat (12) @(posedge clk);
        #1;
        push_counts(0, 7, 0);
        drain();

        // Clear asserted on the exact cycle the debounced edge would increment
        set_btn(1, 2'b10);
        repeat (6) @(posedge clk);
        #1;
        set_clr(1, 2'b10);
        @(posedge clk);
        #1;
        set_clr(1, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        set_btn(1, 2'b00);
        repeat (12) @(posedge clk);
        #1;
        push_counts(1, 0, 0);
        drain();

        // Reset pulse while a press on A channel 0 is mid-debounce
        set_btn(0, 2'b01);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pulse_anode", {4'h0, anode_a}, 8'h0F);
        chk("rst_pulse_cath", cath_a, 8'hFF);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            want = 4'b0001 << (k / 8);
            want = ~want;
            chk("scan_anode", {4'h0, anode_a}, {4'h0, want});
            if (k == 0) chk("scan_digit0_cath", cath_a, 8'hC0);
        end
        @(posedge clk);
        #1;
        repeat (30) @(posedge clk);
        #1;
        push_counts(0, 0, 0);
        push_counts(2, 0, 0);
        drain();
        set_btn(0, 2'b00);
        repeat (20) @(posedge clk);
        #1;
        push_counts(0, 0, 0);
        drain();
        press(0, 2'b01);
        push_counts(0, 1, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
